// File: rtl/ftoi_stage.sv
// ----------------------------------------------------------------------------
// ftoi_stage : registered float32 -> int32 stage with result FIFO,
//              backpressure, flush and sticky overflow status.
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ftoi (
    input  logic [31:0] x,
    output logic [31:0] y,
    output logic        ovf
);
    logic [7:0]  exp_b;
    logic [31:0] mant;
    logic [31:0] mag;

    always_comb begin
        exp_b = x[30:23];
        mant  = {8'd0, 1'b1, x[22:0]};
        ovf   = (exp_b >= 8'd158);
        mag   = '0;
        // Integer weight of the mantissa LSB is 2^(exp-150)
        if (exp_b < 8'd127)
            mag = '0;
        else if (exp_b >= 8'd150)
            mag = mant << (exp_b - 8'd150);
        else
            mag = mant >> (8'd150 - exp_b);
        y = x[31] ? (32'd0 - mag) : mag;
    end
endmodule

module ftoi_stage #(
    parameter int TAG_W = 5,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag,
    input  logic             flush,
    input  logic             ovf_clr,
    output logic             ovf_sticky,
    output logic             busy
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [31:0]      s1_x;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_valid;

    logic [31:0]      fifo_y   [DEPTH];
    logic             fifo_ovf [DEPTH];
    logic [TAG_W-1:0] fifo_tag [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [31:0] conv_y;
    logic        conv_ovf;
    logic [31:0] sat_y;
    logic        head_valid;
    logic        pop;
    logic        s1_adv;
    logic        push;
    logic        accept;

    ftoi u_ftoi (
        .x   (s1_x),
        .y   (conv_y),
        .ovf (conv_ovf)
    );

    assign sat_y      = conv_ovf ? (s1_x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : conv_y;
    assign head_valid = (count != '0);
    assign pop        = head_valid && out_ready && !flush;
    assign s1_adv     = s1_valid && ((count < FULL) || (head_valid && out_ready));
    assign push       = s1_adv && !flush;
    assign in_ready   = !flush && (!s1_valid || s1_adv);
    assign accept     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
        if (accept) begin
            s1_x   <= in_x;
            s1_tag <= in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_y[wr_ptr]   <= sat_y;
            fifo_ovf[wr_ptr] <= conv_ovf;
            fifo_tag[wr_ptr] <= s1_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Set has priority over clear so an overflow popped in the clear cycle is not lost
    always_ff @(posedge clk) begin
        if (rst)
            ovf_sticky <= 1'b0;
        else if (pop && fifo_ovf[rd_ptr])
            ovf_sticky <= 1'b1;
        else if (ovf_clr)
            ovf_sticky <= 1'b0;
    end

    assign out_valid = head_valid;
    assign out_y     = head_valid ? fifo_y[rd_ptr]   : '0;
    assign out_ovf   = head_valid ? fifo_ovf[rd_ptr] : 1'b0;
    assign out_tag   = head_valid ? fifo_tag[rd_ptr] : '0;
    assign busy      = s1_valid || head_valid;

endmodule

`default_nettype wire
